// File: rtl/param_digital_clock.sv
// param_digital_clock: prescaled h:m:s timekeeper with 12/24 h display, validated load and strobes.
// Optional alarm via `DIGITAL_CLOCK_ALARM_EN.
module param_digital_clock #(
  parameter int TICK_DIV = 1,
  parameter int PW = $clog2(TICK_DIV) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       ld,
  input  logic [4:0] ld_h,
  input  logic [5:0] ld_m,
  input  logic [5:0] ld_s,
`ifdef DIGITAL_CLOCK_ALARM_EN
  input  logic       al_on,
  input  logic [4:0] al_h,
  input  logic [5:0] al_m,
  input  logic       al_ack,
  output logic       alarm,
`endif
  output logic [5:0] s,
  output logic [5:0] m,
  output logic [4:0] h,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       ld_err
);
  logic [PW-1:0] cnt;
  logic [4:0] hr, hr_n;
  logic [5:0] s_n, m_n;
  logic tick, ld_ok, ld_go, s_wrap, m_wrap;
  assign tick = en && cnt == PW'(TICK_DIV - 1);
  assign ld_ok = ld_h <= 5'd23 && ld_m <= 6'd59 && ld_s <= 6'd59;
  assign ld_go = ld && ld_ok;
  assign s_wrap = s == 6'd59;
  assign m_wrap = m == 6'd59;
  assign s_n = s_wrap ? 6'd0 : s + 6'd1;
  assign m_n = s_wrap ? (m_wrap ? 6'd0 : m + 6'd1) : m;
  assign hr_n = (s_wrap && m_wrap) ? (hr == 5'd23 ? 5'd0 : hr + 5'd1) : hr;
  assign h = mode_12h ? (hr == 5'd0 ? 5'd12 : hr > 5'd12 ? hr - 5'd12 : hr) : hr;
  assign pm = hr >= 5'd12;
  // A valid load overrides a coincident tick; an invalid one lets it through.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      s <= '0;
      m <= '0;
      hr <= '0;
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      ld_err <= 1'b0;
    end else begin
      sec_tick <= tick && !ld_go;
      day_wrap <= tick && !ld_go && s_wrap && m_wrap && hr == 5'd23;
      ld_err <= ld && !ld_ok;
      if (ld_go) begin
        cnt <= '0;
        s <= ld_s;
        m <= ld_m;
        hr <= ld_h;
      end else if (en) begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          s <= s_n;
          m <= m_n;
          hr <= hr_n;
        end
      end
    end
`ifdef DIGITAL_CLOCK_ALARM_EN
  logic al_set;
  assign al_set = al_on && (ld_go ? (ld_h == al_h && ld_m == al_m && ld_s == 6'd0)
                                  : (tick && s_n == 6'd0 && m_n == al_m && hr_n == al_h));
  always_ff @(posedge clk or negedge rst)
    if (!rst) alarm <= 1'b0;
    else alarm <= (al_ack || !al_on) ? 1'b0 : (alarm || al_set);
`endif
endmodule

// File: tb/tb_param_digital_clock.sv
// tb_param_digital_clock: directed checks of two prescaler settings sharing one stimulus.
module tb_param_digital_clock;
  logic clk = 1'b0;
  logic rst, en, mode_12h, ld;
  logic [4:0] ld_h;
  logic [5:0] ld_m, ld_s;
  logic [5:0] s1, m1, s4, m4;
  logic [4:0] h1, h4;
  logic pm1, pm4, st1, st4, dw1, dw4, le1, le4;
`ifdef DIGITAL_CLOCK_ALARM_EN
  logic al_on, al_ack, alarm1, alarm4;
  logic [4:0] al_h;
  logic [5:0] al_m;
`endif
  int checks = 0, failures = 0, pulses;
  always #5 clk = ~clk;

  param_digital_clock #(.TICK_DIV(1)) d1 (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .ld(ld), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
`ifdef DIGITAL_CLOCK_ALARM_EN
    .al_on(al_on), .al_h(al_h), .al_m(al_m), .al_ack(al_ack), .alarm(alarm1),
`endif
    .s(s1), .m(m1), .h(h1), .pm(pm1), .sec_tick(st1), .day_wrap(dw1), .ld_err(le1));

  param_digital_clock #(.TICK_DIV(4)) d4 (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .ld(ld), .ld_h(ld_h), .ld_m(ld_m), .ld_s(ld_s),
`ifdef DIGITAL_CLOCK_ALARM_EN
    .al_on(al_on), .al_h(al_h), .al_m(al_m), .al_ack(al_ack), .alarm(alarm4),
`endif
    .s(s4), .m(m4), .h(h4), .pm(pm4), .sec_tick(st4), .day_wrap(dw4), .ld_err(le4));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int hh, input int mm, input int ss);
    ld = 1'b1;
    ld_h = 5'(hh);
    ld_m = 6'(mm);
    ld_s = 6'(ss);
    cyc(1);
    ld = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode_12h = 1'b0; ld = 1'b0; ld_h = '0; ld_m = '0; ld_s = '0;
`ifdef DIGITAL_CLOCK_ALARM_EN
    al_on = 1'b0; al_ack = 1'b0; al_h = '0; al_m = '0;
`endif
    cyc(2);
    chk("rst_s", s1, 0); chk("rst_m", m1, 0); chk("rst_h24", h1, 0); chk("rst_pm", pm1, 0);
    chk("rst_tick", st1, 0); chk("rst_wrap", dw1, 0); chk("rst_err", le1, 0);
    mode_12h = 1'b1; #1;
    chk("rst_h12", h1, 12);
    mode_12h = 1'b0;
    cyc(1);
    // free-run at one tick per cycle
    rst = 1'b1; en = 1'b1; pulses = 0;
    for (int i = 1; i <= 61; i++) begin
      cyc(1);
      pulses += int'(st1);
      if (i == 60) begin chk("run60_s", s1, 0); chk("run60_m", m1, 1); end
    end
    chk("run61_s", s1, 1); chk("run61_m", m1, 1); chk("run61_pulses", pulses, 61);
    #2 rst = 1'b0; #1;
    chk("async_s1", s1, 0); chk("async_m1", m1, 0); chk("async_s4", s4, 0);
    cyc(1);
    // divide-by-4 prescaler, then hold
    rst = 1'b1; en = 1'b1;
    cyc(11); chk("div4_s11", s4, 2); chk("div4_notick", st4, 0);
    cyc(1); chk("div4_s12", s4, 3); chk("div4_tick", st4, 1);
    en = 1'b0; pulses = 0;
    for (int i = 0; i < 10; i++) begin cyc(1); pulses += int'(st4); end
    chk("hold_pulses", pulses, 0); chk("hold_s", s4, 3);
    // day rollover
    load(23, 59, 59);
    chk("ld_h", h1, 23); chk("ld_m", m1, 59); chk("ld_s", s1, 59); chk("ld_pm", pm1, 1); chk("ld_tick", st1, 0);
    en = 1'b1; cyc(1); en = 1'b0;
    chk("wrap_s", s1, 0); chk("wrap_m", m1, 0); chk("wrap_h", h1, 0); chk("wrap_pm", pm1, 0);
    chk("wrap_strobe", dw1, 1); chk("wrap_tick", st1, 1);
    cyc(1); chk("wrap_once", dw1, 0); chk("tick_once", st1, 0);
    // rejected loads
    load(24, 0, 0);
    chk("bad_h_err", le1, 1); chk("bad_h_keep", h1, 0); chk("bad_h_s", s1, 0);
    cyc(1); chk("err_once", le1, 0);
    load(10, 60, 0);
    chk("bad_m_err", le1, 1); chk("bad_m_h", h1, 0); chk("bad_m_m", m1, 0);
    load(10, 0, 60);
    chk("bad_s_err", le1, 1); chk("bad_s_s", s1, 0);
    // load vs tick in the same cycle
    en = 1'b1; load(5, 6, 7); en = 1'b0;
    chk("ldtick_s", s1, 7); chk("ldtick_m", m1, 6); chk("ldtick_h", h1, 5); chk("ldtick_notick", st1, 0);
    chk("ldtick_err", le1, 0);
    en = 1'b1; load(24, 6, 7); en = 1'b0;
    chk("badtick_s", s1, 8); chk("badtick_err", le1, 1); chk("badtick_tick", st1, 1);
    // 12 h display
    mode_12h = 1'b1;
    load(0, 0, 0); chk("m12_0_h", h1, 12); chk("m12_0_pm", pm1, 0);
    load(13, 5, 0); chk("m12_13_h", h1, 1); chk("m12_13_pm", pm1, 1); chk("m12_13_m", m1, 5);
    load(12, 0, 0); chk("m12_12_h", h1, 12); chk("m12_12_pm", pm1, 1);
    load(11, 0, 0); chk("m12_11_h", h1, 11); chk("m12_11_pm", pm1, 0);
    load(23, 0, 0); chk("m12_23_h", h1, 11); chk("m12_23_pm", pm1, 1);
    mode_12h = 1'b0; #1; chk("m24_23_h", h1, 23);
`ifdef DIGITAL_CLOCK_ALARM_EN
    al_on = 1'b1; al_h = 5'd7; al_m = 6'd30;
    load(7, 29, 59); chk("al_pre", alarm1, 0);
    en = 1'b1; cyc(1); en = 1'b0;
    chk("al_tick", alarm1, 1); chk("al_div4_quiet", alarm4, 0);
    cyc(2); chk("al_hold", alarm1, 1);
    al_ack = 1'b1; cyc(1); al_ack = 1'b0; chk("al_ack", alarm1, 0);
    load(7, 30, 0); chk("al_load1", alarm1, 1); chk("al_load4", alarm4, 1);
    al_on = 1'b0; cyc(1); chk("al_off", alarm1, 0);
    al_on = 1'b1; load(7, 30, 0); chk("al_reload", alarm1, 1);
`endif
    // reset in the middle of counting
    en = 1'b1; cyc(3);
    chk("pre_rst_tick", st1, 1);
    #2 rst = 1'b0; #1;
    chk("mid_s", s1, 0); chk("mid_m", m1, 0); chk("mid_h", h1, 0); chk("mid_pm", pm1, 0);
    chk("mid_tick", st1, 0); chk("mid_wrap", dw1, 0); chk("mid_err", le1, 0);
`ifdef DIGITAL_CLOCK_ALARM_EN
    chk("mid_alarm", alarm1, 0);
`endif
    cyc(1); rst = 1'b1;
    cyc(2); chk("resume_s", s1, 2); chk("resume_s4", s4, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
